// File: rtl/sha1_exec.sv
// sha1_exec -- SHA-1 compression engine, one pre-padded 512-bit block per run.
//
// The block is shifted in as 16 x 32-bit words (first word = W0). A start
// pulse in IDLE launches 80 rounds, one per clock. The result
// (H + final a..e, per 32-bit word) lands on cv_next when busy falls.
// Multi-block messages chain by asserting use_prev_cv at start, which takes
// the held cv_next as the incoming chaining value instead of cv.
//
// Ports:
//   clk          in   1    rising-edge clock
//   reset        in   1    synchronous, active-high reset
//   start        in   1    begin compression of the loaded block (ignored while busy)
//   data_in      in   32   message word to load
//   load_in      in   1    shift data_in into the block buffer (ignored while busy)
//   cv           in   160  chaining value H0..H4, H0 in [159:128]
//   use_prev_cv  in   1    at start: use cv_next instead of cv
//   busy         out  1    high while rounds execute (80 cycles)
//   out_valid    out  1    result-valid strobe
//   cv_next      out  160  result H0'..H4', H0' in [159:128]
//
// Configuration macro:
//   SHA1_EXEC_HOLD_VALID_EN  undefined: out_valid is a one-cycle pulse at completion.
//                            defined:   out_valid stays high from completion until
//                                       the next accepted start, or reset.

module sha1_exec (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [31:0]  data_in,
   input  logic         load_in,
   input  logic [159:0] cv,
   input  logic         use_prev_cv,
   output logic         busy,
   output logic         out_valid,
   output logic [159:0] cv_next
);

   typedef enum logic {IDLE, ROUND} state_t;

   state_t state, state_nx;

   logic [6:0]        t;
   // Block buffer; after start the same registers act as the 16-word
   // schedule window, win[0] always holding W_t for the current round.
   logic [15:0][31:0] win;
   logic [31:0]       a, b, c, d, e;
   logic [159:0]      h;

   logic [31:0] f, k, tmp, w_new, w_x;
   logic [31:0] a_n, b_n, c_n, d_n, e_n;
   logic [159:0] h_sel;
   logic        start_ok, last;

   // ---------------------------------------------------------------
   // Round datapath
   // ---------------------------------------------------------------
   always_comb begin
      f = 32'h0;
      k = 32'h0;
      if (t < 7'd20) begin
         f = (b & c) | (~b & d);
         k = 32'h5A827999;
      end else if (t < 7'd40) begin
         f = b ^ c ^ d;
         k = 32'h6ED9EBA1;
      end else if (t < 7'd60) begin
         f = (b & c) | (b & d) | (c & d);
         k = 32'h8F1BBCDC;
      end else begin
         f = b ^ c ^ d;
         k = 32'hCA62C1D6;
      end
   end

   assign tmp = {a[26:0], a[31:27]} + f + e + k + win[0];

   // Word t+16 of the schedule: W[t+13]^W[t+8]^W[t+2]^W[t], rotated by one.
   assign w_x   = win[13] ^ win[8] ^ win[2] ^ win[0];
   assign w_new = {w_x[30:0], w_x[31]};

   assign a_n = tmp;
   assign b_n = a;
   assign c_n = {b[1:0], b[31:2]};
   assign d_n = c;
   assign e_n = d;

   assign start_ok = (state == IDLE) && start;
   assign last     = (state == ROUND) && (t == 7'd79);
   assign h_sel    = use_prev_cv ? cv_next : cv;
   assign busy     = (state == ROUND);

   // ---------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = ROUND;
         ROUND:   if (t == 7'd79) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         t       <= 7'd0;
         win     <= '0;
         a       <= 32'h0;
         b       <= 32'h0;
         c       <= 32'h0;
         d       <= 32'h0;
         e       <= 32'h0;
         h       <= '0;
         cv_next <= '0;
      end else if (state == IDLE) begin
         // start wins over a simultaneous load: the block is taken as it
         // stood before this edge and the load is dropped.
         if (start) begin
            h <= h_sel;
            a <= h_sel[159:128];
            b <= h_sel[127:96];
            c <= h_sel[95:64];
            d <= h_sel[63:32];
            e <= h_sel[31:0];
            t <= 7'd0;
         end else if (load_in) begin
            win <= {data_in, win[15:1]};
         end
      end else begin
         a   <= a_n;
         b   <= b_n;
         c   <= c_n;
         d   <= d_n;
         e   <= e_n;
         win <= {w_new, win[15:1]};
         t   <= last ? 7'd0 : t + 7'd1;
         if (last)
            cv_next <= {h[159:128] + a_n,
                        h[127:96]  + b_n,
                        h[95:64]   + c_n,
                        h[63:32]   + d_n,
                        h[31:0]    + e_n};
      end
   end

   // ---------------------------------------------------------------
   // Result strobe
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
      end else begin
`ifdef SHA1_EXEC_HOLD_VALID_EN
         if (last)          out_valid <= 1'b1;
         else if (start_ok) out_valid <= 1'b0;
`else
         out_valid <= last;
`endif
      end
   end

endmodule

// File: tb/tb_sha1_exec.sv
// tb_sha1_exec -- scoreboard bench for sha1_exec.
// Each run pushes its expected digest at start; a negedge monitor pops one
// entry on every rising out_valid and compares cv_next.

module tb_sha1_exec;

   logic         clk, reset, start, load_in, use_prev_cv;
   logic [31:0]  data_in;
   logic [159:0] cv;
   logic         busy, out_valid;
   logic [159:0] cv_next;

   sha1_exec dut (
      .clk(clk), .reset(reset), .start(start), .data_in(data_in),
      .load_in(load_in), .cv(cv), .use_prev_cv(use_prev_cv),
      .busy(busy), .out_valid(out_valid), .cv_next(cv_next)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [159:0] H_INIT  = 160'h67452301efcdab8998badcfe10325476c3d2e1f0;
   localparam logic [159:0] ABC_DIG = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
   localparam logic [159:0] TWO_DIG = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;

   typedef struct {
      bit           chk;
      logic [159:0] val;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic ov_prev = 1'b0;

   logic [15:0][31:0] abc_blk, blk1, blk2;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: one result per rising out_valid.
   always @(negedge clk) begin
      if (!reset && out_valid && !ov_prev) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: got cv_next %h expected no result", cv_next);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (e.chk) chk("digest", cv_next, e.val);
         end
      end
      ov_prev = out_valid;
   end

   // Load a block, start, watch busy. abort_at>0 resets the engine after
   // that many busy cycles and expects no result from the run.
   task automatic run(input logic [15:0][31:0] blk, input logic up,
                      input logic [159:0] cvi, input bit chk_en,
                      input logic [159:0] exp, input bit disturb,
                      input bit ld_at_start, input int abort_at);
      int cnt;
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         load_in = 1'b1;
         data_in = blk[i];
      end
      @(posedge clk); #1;
      load_in     = ld_at_start;
      data_in     = 32'hdeadbeef;
      start       = 1'b1;
      cv          = cvi;
      use_prev_cv = up;
      if (abort_at == 0) sb.push_back('{chk_en, exp});
      @(posedge clk); #1;
      start   = 1'b0;
      load_in = 1'b0;
      cv      = {5{32'h0badf00d}};
      while (cnt < 200) begin
         @(negedge clk);
         if (!busy) break;
         cnt++;
         if (disturb) begin
            load_in     = 1'($urandom_range(0, 1));
            data_in     = $urandom;
            start       = ~start;
            use_prev_cv = ~use_prev_cv;
         end
         if (abort_at > 0 && cnt == abort_at) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            chk("abort_busy", {159'd0, busy}, 160'd0);
            chk("abort_out_valid", {159'd0, out_valid}, 160'd0);
            chk("abort_cv_next", cv_next, 160'd0);
            repeat (90) @(negedge clk);
            return;
         end
      end
      start       = 1'b0;
      load_in     = 1'b0;
      use_prev_cv = 1'b0;
      chk("busy_len", 160'(cnt), 160'd80);
      @(negedge clk);
`ifdef SHA1_EXEC_HOLD_VALID_EN
      chk("valid_held", {159'd0, out_valid}, 160'd1);
`else
      chk("valid_pulse", {159'd0, out_valid}, 160'd0);
`endif
   endtask

   initial begin
      logic [0:15][31:0] tmp;
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [0:15][31:0] w;
      abc_blk     = '0;
      abc_blk[0]  = 32'h61626380;
      abc_blk[15] = 32'h00000018;
      w = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
           32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
           32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
           32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
      for (int i = 0; i < 16; i++) blk1[i] = w[i];
      blk2     = '0;
      blk2[15] = 32'h000001c0;

      reset = 1'b1; start = 1'b0; load_in = 1'b0; use_prev_cv = 1'b0;
      data_in = 32'h0; cv = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", {159'd0, busy}, 160'd0);
      chk("reset_out_valid", {159'd0, out_valid}, 160'd0);
      chk("reset_cv_next", cv_next, 160'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // "abc"
      run(abc_blk, 1'b0, H_INIT, 1'b1, ABC_DIG, 1'b0, 1'b0, 0);
      repeat (5) @(negedge clk);
      chk("cv_next_hold", cv_next, ABC_DIG);

      // Two-block message, second block chained with garbage on cv
      run(blk1, 1'b0, H_INIT, 1'b0, '0, 1'b0, 1'b0, 0);
      run(blk2, 1'b1, {5{32'h12345678}}, 1'b1, TWO_DIG, 1'b0, 1'b0, 0);

      // load_in / start / use_prev_cv thrashed during rounds
      run(abc_blk, 1'b0, H_INIT, 1'b1, ABC_DIG, 1'b1, 1'b0, 0);

      // load_in together with start: load discarded
      run(abc_blk, 1'b0, H_INIT, 1'b1, ABC_DIG, 1'b0, 1'b1, 0);

      // Reset at round 40, then rerun
      run(abc_blk, 1'b0, H_INIT, 1'b0, '0, 1'b0, 1'b0, 40);
      run(abc_blk, 1'b0, H_INIT, 1'b1, ABC_DIG, 1'b0, 1'b0, 0);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      chk("sb_drained", 160'(sb.size()), 160'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
